// File: rtl/cache_pkg.sv
// Shared cache definitions: refill FSM state encoding, geometry helpers and
// {tag,index,offset} address slicing macros also used by the cache control FSM.
`ifndef CACHE_PKG_SV
`define CACHE_PKG_SV

`define CACHE_OFFSET(a, off_w)                 a[(off_w)-1:0]
`define CACHE_INDEX(a, off_w, index_w)         a[(off_w)+(index_w)-1:(off_w)]
`define CACHE_TAG(a, addr_w, off_w, index_w)   a[(addr_w)-1:(off_w)+(index_w)]

package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WB_RD    = 3'd1,
    ST_WB_REQ   = 3'd2,
    ST_FILL_REQ = 3'd3,
    ST_FILL_WR  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  function automatic int off_w_of(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int tag_w_of(input int addr_w, input int index_w, input int line_words);
    return addr_w - index_w - $clog2(line_words);
  endfunction

endpackage

`endif

// File: rtl/line_beat_ctr.sv
// Beat counter for line transfers: loadable start word, wrapping word index,
// and a separate beat count so "last" means the LINE_WORDS-th beat.
module line_beat_ctr #(
  parameter  int LINE_WORDS = 4,
  localparam int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OFF_W-1:0] start,
  input  logic             inc,
  output logic [OFF_W-1:0] idx,
  output logic             last
);

  logic [OFF_W-1:0] beat_q;

  // LINE_WORDS is a power of two, so natural overflow is the modulo wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      beat_q <= '0;
    end else if (load) begin
      idx    <= start;
      beat_q <= '0;
    end else if (inc) begin
      idx    <= idx + 1'b1;
      beat_q <= beat_q + 1'b1;
    end
  end

  assign last = (beat_q == OFF_W'(LINE_WORDS - 1));

endmodule

// File: rtl/line_refill_ctrl.sv
// Miss sequencer: optional dirty-line writeback, then line refill into the data array.
// Build option CRITICAL_WORD_FIRST_EN: fill from the missing word's offset, add crit_valid/crit_data.
import cache_pkg::*;

module line_refill_ctrl #(
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  parameter  int LINE_WORDS = 4,
  parameter  int INDEX_W    = 6,
  localparam int OFF_W      = off_w_of(LINE_WORDS),
  localparam int TAG_W      = tag_w_of(ADDR_W, INDEX_W, LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_dirty,
  input  logic [TAG_W-1:0]  req_victim_tag,
  output logic              arr_rd_en,
  output logic              arr_wr_en,
  output logic [OFF_W-1:0]  arr_word_idx,
  output logic [DATA_W-1:0] arr_wdata,
  input  logic [DATA_W-1:0] arr_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
`ifdef CRITICAL_WORD_FIRST_EN
  ,
  output logic              crit_valid,
  output logic [DATA_W-1:0] crit_data
`endif
);

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, vtag_q;
  logic [INDEX_W-1:0] index_q;
  logic               wb_first_q;
  logic [DATA_W-1:0]  wb_data_q, fill_data_q;
  logic               ctr_load, ctr_inc, ctr_last;
  logic [OFF_W-1:0]   ctr_start, cnt;
  logic [OFF_W-1:0]   fill_start_new, fill_start_lat;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0]   off_q;
  logic               crit_pend_q;
  assign fill_start_new = `CACHE_OFFSET(req_addr, OFF_W);
  assign fill_start_lat = off_q;
`else
  logic               unused_off;
  assign unused_off     = ^`CACHE_OFFSET(req_addr, OFF_W);
  assign fill_start_new = '0;
  assign fill_start_lat = '0;
`endif

  assign dbg_state = state_q;

  line_beat_ctr #(.LINE_WORDS(LINE_WORDS)) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .load  (ctr_load),
    .start (ctr_start),
    .inc   (ctr_inc),
    .idx   (cnt),
    .last  (ctr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tag_q       <= '0;
      index_q     <= '0;
      vtag_q      <= '0;
      wb_first_q  <= 1'b0;
      wb_data_q   <= '0;
      fill_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        tag_q   <= `CACHE_TAG(req_addr, ADDR_W, OFF_W, INDEX_W);
        index_q <= `CACHE_INDEX(req_addr, OFF_W, INDEX_W);
        vtag_q  <= req_victim_tag;
      end
      // array read data arrives in the first WB_REQ cycle; hold it for stalled beats
      wb_first_q <= (state_q == ST_WB_RD);
      if (wb_first_q) wb_data_q <= arr_rdata;
      if (state_q == ST_FILL_REQ && mem_ack) fill_data_q <= mem_rdata;
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q       <= '0;
      crit_pend_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && req_valid) off_q <= `CACHE_OFFSET(req_addr, OFF_W);
      if (state_d == ST_FILL_REQ && (state_q == ST_IDLE || state_q == ST_WB_REQ))
        crit_pend_q <= 1'b1;
      else if (state_q == ST_FILL_WR)
        crit_pend_q <= 1'b0;
    end
  end

  assign crit_valid = (state_q == ST_FILL_WR) && crit_pend_q;
  assign crit_data  = crit_valid ? fill_data_q : '0;
`endif

  always_comb begin
    state_d      = state_q;
    ctr_load     = 1'b0;
    ctr_start    = '0;
    ctr_inc      = 1'b0;
    req_ready    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    arr_rd_en    = 1'b0;
    arr_wr_en    = 1'b0;
    arr_word_idx = '0;
    arr_wdata    = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    unique case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = 1'b1;
        if (req_valid) begin
          ctr_load  = 1'b1;
          ctr_start = req_dirty ? '0 : fill_start_new;
          state_d   = req_dirty ? ST_WB_RD : ST_FILL_REQ;
        end
      end
      ST_WB_RD: begin
        arr_rd_en    = 1'b1;
        arr_word_idx = cnt;
        state_d      = ST_WB_REQ;
      end
      ST_WB_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vtag_q, index_q, cnt};
        mem_wdata = wb_first_q ? arr_rdata : wb_data_q;
        if (mem_ack) begin
          if (ctr_last) begin
            ctr_load  = 1'b1;
            ctr_start = fill_start_lat;
            state_d   = ST_FILL_REQ;
          end else begin
            ctr_inc = 1'b1;
            state_d = ST_WB_RD;
          end
        end
      end
      ST_FILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {tag_q, index_q, cnt};
        if (mem_ack) state_d = ST_FILL_WR;
      end
      ST_FILL_WR: begin
        arr_wr_en    = 1'b1;
        arr_wdata    = fill_data_q;
        arr_word_idx = cnt;
        if (ctr_last) begin
          state_d = ST_DONE;
        end else begin
          ctr_inc = 1'b1;
          state_d = ST_FILL_REQ;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Directed bench for line_refill_ctrl: memory/array models, beat logs checked
// against hand-built expected queues, latency, stall hold, reset abort, back-to-back.
`timescale 1ns/1ps
module tb_line_refill_ctrl;
  import cache_pkg::*;

  localparam int ADDR_W = 32, DATA_W = 32, LINE_WORDS = 4, INDEX_W = 6;
  localparam int OFF_W = 2, TAG_W = 24;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF_EN = 1'b1;
`else
  localparam bit CWF_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_dirty;
  logic [ADDR_W-1:0] req_addr;
  logic [TAG_W-1:0]  req_victim_tag;
  logic              arr_rd_en, arr_wr_en;
  logic [OFF_W-1:0]  arr_word_idx;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy, done;
  state_t            dbg_state;
`ifdef CRITICAL_WORD_FIRST_EN
  logic              crit_valid;
  logic [DATA_W-1:0] crit_data;
`endif

  line_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_dirty(req_dirty), .req_victim_tag(req_victim_tag),
    .arr_rd_en(arr_rd_en), .arr_wr_en(arr_wr_en), .arr_word_idx(arr_word_idx),
    .arr_wdata(arr_wdata), .arr_rdata(arr_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .dbg_state(dbg_state)
`ifdef CRITICAL_WORD_FIRST_EN
    , .crit_valid(crit_valid), .crit_data(crit_data)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters / check ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- memory and array models ----------------
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[15:0]};
  endfunction

  function automatic logic [31:0] arr_data(input logic [1:0] i);
    return 32'hC0DE_0000 + {30'd0, i} * 32'h0101;
  endfunction

  function automatic logic [1:0] fill_start(input logic [31:0] a);
    return CWF_EN ? a[1:0] : 2'd0;
  endfunction

  int stall_cfg = 0;
  int wait_left;

  assign mem_ack   = mem_req && (wait_left == 0);
  assign mem_rdata = mem_req ? mem_data(mem_addr) : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst)          wait_left <= stall_cfg;
    else if (!mem_req) wait_left <= stall_cfg;
    else              wait_left <= mem_ack ? stall_cfg : wait_left - 1;
  end

  // read data is only valid the cycle after a strobe; garbage otherwise
  always @(posedge clk or posedge rst) begin
    if (rst) arr_rdata <= 32'hBAD0_BAD0;
    else     arr_rdata <= arr_rd_en ? arr_data(arr_word_idx) : 32'hBAD0_BAD0;
  end

  // ---------------- monitor ----------------
  logic [71:0] exp_q[$], exp_wr_q[$], exp_rd_q[$];
  logic [71:0] obs_mem[$], obs_wr[$], obs_rd[$], obs_crit[$];
  int   cyc = 0, acc_cyc = 0, lat = 0, done_cnt = 0, hold_err = 0, ready_in_done = 0;
  logic pend = 1'b0;
  logic [64:0] pend_val;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (done) begin
        done_cnt++;
        lat = cyc - acc_cyc;
        if (req_ready) ready_in_done++;
      end
      if (pend && mem_req && ({mem_we, mem_addr, mem_wdata} !== pend_val)) hold_err++;
      pend     = mem_req && !mem_ack;
      pend_val = {mem_we, mem_addr, mem_wdata};
      if (mem_req && mem_ack)
        obs_mem.push_back({7'd0, mem_we, mem_addr, mem_we ? mem_wdata : 32'h0});
      if (arr_wr_en) obs_wr.push_back({38'd0, arr_word_idx, arr_wdata});
      if (arr_rd_en) obs_rd.push_back({70'd0, arr_word_idx});
`ifdef CRITICAL_WORD_FIRST_EN
      if (crit_valid) obs_crit.push_back({40'd0, crit_data});
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [31:0] a, input logic d, input logic [23:0] vt);
    bit ok = 0;
    @(posedge clk); #1;
    req_addr = a; req_dirty = d; req_victim_tag = vt; req_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_dirty = 1'b0;
    if (!ok) check("accept_timeout", 72'd0, 72'd1);
  endtask

  task automatic wait_done(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    if (!ok) check("done_timeout", 72'd0, 72'd1);
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    exp_q.delete(); exp_wr_q.delete(); exp_rd_q.delete();
    obs_mem.delete(); obs_wr.delete(); obs_rd.delete(); obs_crit.delete();
    hold_err = 0;
  endtask

  task automatic compare_q(input string tag, input logic [71:0] e[$], input logic [71:0] o[$]);
    check({tag, "_len"}, 72'(o.size()), 72'(e.size()));
    for (int i = 0; i < e.size() && i < o.size(); i++) check(tag, o[i], e[i]);
  endtask

  task automatic run_miss(input string name, input logic [31:0] a, input logic d,
                          input logic [23:0] vt, input int stall, input int exp_lat);
    int d0;
    logic [1:0]  st, w;
    logic [31:0] fa;
    clear_logs();
    stall_cfg = stall;
    d0 = done_cnt;
    if (d) begin
      for (int i = 0; i < 4; i++) begin
        exp_rd_q.push_back(72'(i));
        exp_q.push_back({7'd0, 1'b1, vt, a[7:2], 2'(i), arr_data(2'(i))});
      end
    end
    st = fill_start(a);
    for (int k = 0; k < 4; k++) begin
      w  = st + 2'(k);
      fa = {a[31:2], w};
      exp_q.push_back({7'd0, 1'b0, fa, 32'h0});
      exp_wr_q.push_back({38'd0, w, mem_data(fa)});
    end
    do_req(a, d, vt);
    wait_done(300);
    repeat (2) @(negedge clk);
    check({name, "_latency"}, 72'(lat), 72'(exp_lat));
    check({name, "_done_cnt"}, 72'(done_cnt - d0), 72'd1);
    check({name, "_hold"}, 72'(hold_err), 72'd0);
    compare_q({name, "_mem"}, exp_q, obs_mem);
    compare_q({name, "_arr_wr"}, exp_wr_q, obs_wr);
    compare_q({name, "_arr_rd"}, exp_rd_q, obs_rd);
`ifdef CRITICAL_WORD_FIRST_EN
    check({name, "_crit_len"}, 72'(obs_crit.size()), 72'd1);
    if (obs_crit.size() > 0)
      check({name, "_crit_data"}, obs_crit[0], {40'd0, mem_data({a[31:2], st})});
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, dd, aa, t_done, t_acc2;
    bit seen;
    rst = 1'b1; req_valid = 1'b0; req_dirty = 1'b0; req_addr = '0; req_victim_tag = '0;
    #1;
    check("rst_req_ready", 72'(req_ready), 72'd1);
    check("rst_busy", 72'(busy), 72'd0);
    check("rst_mem_req", 72'(mem_req), 72'd0);
    check("rst_strobes", {70'd0, arr_rd_en, arr_wr_en}, 72'd0);
    check("rst_done", 72'(done), 72'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    run_miss("clean",     32'h0000_0042, 1'b0, 24'h0,     0, 9);
    run_miss("dirty",     32'h0000_7706, 1'b1, 24'h5,     0, 17);
    run_miss("stall",     32'h1234_5678, 1'b1, 24'hABCDE, 3, 41);
    run_miss("clean_st",  32'h0000_0129, 1'b0, 24'h0,     2, 17);

    // reset during second writeback beat
    clear_logs();
    stall_cfg = 3;
    d0 = done_cnt;
    do_req(32'h0000_0A14, 1'b1, 24'h33);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (obs_mem.size() == 1 && dbg_state == ST_WB_REQ) seen = 1;
    end
    check("abort_reach_beat2", 72'(seen), 72'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_mem_req", 72'(mem_req), 72'd0);
    check("abort_busy", 72'(busy), 72'd0);
    check("abort_ready_in_rst", 72'(req_ready), 72'd1);
    @(posedge clk); @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_ready_after", 72'(req_ready), 72'd1);
    check("abort_no_done", 72'(done_cnt - d0), 72'd0);
    run_miss("post_abort", 32'h0000_0042, 1'b0, 24'h0, 0, 9);

    // back-to-back with req_valid held
    stall_cfg = 0;
    dd = 0; aa = 0; t_done = 0; t_acc2 = 0; d0 = ready_in_done;
    @(posedge clk); #1;
    req_addr = 32'h0000_0100; req_dirty = 1'b0; req_victim_tag = '0; req_valid = 1'b1;
    for (int c = 0; c < 100 && dd < 2; c++) begin
      @(negedge clk);
      if (req_valid && req_ready) begin aa++; if (aa == 2) t_acc2 = c; end
      if (done) begin dd++; if (dd == 1) t_done = c; if (dd == 2) req_valid = 1'b0; end
    end
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) dd++;
      if (req_valid && req_ready) aa++;
    end
    check("b2b_accepts", 72'(aa), 72'd2);
    check("b2b_dones", 72'(dd), 72'd2);
    check("b2b_gap", 72'(t_acc2 - t_done), 72'd1);
    check("b2b_ready_in_done", 72'(ready_in_done - d0), 72'd0);

    // critical-word offset 3 (order 3,0,1,2 when the feature is built in)
    run_miss("crit3", 32'h0000_02F3, 1'b0, 24'h0, 0, 9);
    run_miss("crit3_dirty", 32'h0000_02F3, 1'b1, 24'h7, 1, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_refill_ctrl.md
Name: line_refill_ctrl

Overview:
- Miss sequencer between the 4-way cache control FSM and the single-ported backing memory.
- On a miss request, optionally writes back the dirty victim line word by word from the data array.
- Then refills the line from memory into the data array and pulses completion back to the cache FSM.
- The cache FSM owns hit detection and victim selection. This block owns all memory traffic and beat counting.

Parameters:
- ADDR_W, 32, word-address width.
- DATA_W, 32, data word width.
- LINE_WORDS, 4, words per line; power of 2, at least 2.
- INDEX_W, 6, set-index width.
- Derived localparams: OFF_W = log2(LINE_WORDS); TAG_W = ADDR_W-INDEX_W-OFF_W.

Ports:
- clk  in  1  Clock.
- rst  in  1  Reset.
- req_valid  in  1  Miss request.
- req_ready  out  1  High only in IDLE.
- req_addr  in  ADDR_W  Missing word address; fields are {tag,index,offset}.
- req_dirty  in  1  Victim line is dirty.
- req_victim_tag  in  TAG_W  Tag of the victim line.
- arr_rd_en  out  1  Data array read strobe; read data returns on arr_rdata the next cycle.
- arr_wr_en  out  1  Data array write strobe.
- arr_word_idx  out  OFF_W  Word within the line (index comes from the latched address).
- arr_wdata  out  DATA_W  Data array write data.
- arr_rdata  in  DATA_W  Data array read data.
- mem_req  out  1  Memory beat request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  Memory beat address.
- mem_wdata  out  DATA_W  Memory write data.
- mem_ack  in  1  Beat accepted/completed; mem_rdata valid this cycle for reads.
- mem_rdata  in  DATA_W  Memory read data.
- busy  out  1  Not in IDLE.
- done  out  1  One-cycle completion pulse.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset forces state IDLE, beat counter 0 and all latched fields 0.
- All outputs are 0 during and after reset, except req_ready = 1.
- States: IDLE, WB_RD, WB_REQ, FILL_REQ, FILL_WR, DONE.
- IDLE:
  - When req_valid is high, latch addr, dirty and victim_tag.
  - Go to WB_RD if dirty, else FILL_REQ; counter = 0.
- WB_RD:
  - arr_rd_en=1, arr_word_idx=cnt.
  - Next state WB_REQ; arr_rdata is captured into the wdata register on entry.
- WB_REQ:
  - mem_req=1, mem_we=1, mem_addr={victim_tag,index,cnt}.
  - Hold until mem_ack. On ack: last beat -> FILL_REQ with cnt=0; otherwise cnt++ -> WB_RD.
- FILL_REQ:
  - mem_req=1, mem_we=0, mem_addr={tag,index,cnt}.
  - On mem_ack: capture mem_rdata, go to FILL_WR.
- FILL_WR:
  - arr_wr_en=1, arr_wdata=captured word, arr_word_idx=cnt.
  - Last beat -> DONE; otherwise cnt++ -> FILL_REQ.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - req_ready returns the following cycle; back-to-back requests are therefore spaced by at least one IDLE cycle.
- Memory handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req is high and unacked.
  - mem_ack is ignored when mem_req is low.
  - Same-cycle ack is legal, giving a minimum of 2 cycles per beat.
- Latency with zero-wait memory:
  - Clean miss: done asserts 1+2*LINE_WORDS cycles after acceptance (9 for defaults).
  - Dirty miss adds 2*LINE_WORDS cycles.
- Counter wraps modulo LINE_WORDS. "Last" means the LINE_WORDS-th beat, not cnt==max.
- req_valid is ignored while busy.
- Reset mid-transaction abandons it: no done pulse; mem_req drops immediately (asynchronously). Memory must tolerate an abandoned beat.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - Fill starts at req_addr's offset and wraps, e.g. offset 2 gives order 2,3,0,1.
  - Extra outputs crit_valid (1) and crit_data (DATA_W) pulse in the first FILL_WR cycle with that word.
  - Writeback order is unchanged (from 0).
- Undefined: fill always starts at 0; the crit ports do not exist.

Decomposition:
- Shared package cache_pkg holds:
  - state encodings;
  - the OFF_W/TAG_W derivation constants;
  - address field slicing macros (TAG/INDEX/OFFSET), shared with the cache control FSM.
- One sub-module, line_beat_ctr:
  - loadable start offset, increment, modulo-LINE_WORDS wrap, beat count, last flag.
  - Used for both writeback and fill.

Test Plan:
- Clean miss, req_addr=0x0000_0042, zero-wait ack -> 4 mem reads at 0x40..0x43, 4 arr writes idx 0..3, done 9 cycles after accept.
- Dirty miss, victim_tag=0x5, index 1 -> 4 array reads, then mem writes at {0x5,1,0..3} with matching arr_rdata, then 4 fills; done at cycle 17.
- Memory stalls ack for 3 cycles on every beat -> mem_addr/mem_wdata held constant, no extra array strobes, data order correct.
- Reset asserted during the second WB_REQ beat -> outputs 0 immediately, req_ready=1 after release, no done; a new clean request then completes normally.
- req_valid held high through DONE -> second request accepted only after the IDLE cycle, exactly one done per request.
- CRITICAL_WORD_FIRST_EN, req offset 3 -> fill order 3,0,1,2; crit_valid with word 3 data in the first FILL_WR cycle.
